// File: rtl/modexp_pkg.sv
// modexp_pkg: shared state/op enums and default parameters for the modexp sequencer
package modexp_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic [1:0] {REDUCE, SQR, MUL} op_e;
  localparam int DEF_W = 16;
  localparam int DEF_TIMEOUT = 1023;
endpackage

// File: rtl/modexp_sequencer_if.sv
// modexp_sequencer_if: request/response and modular-multiplier handshake bundle
interface modexp_sequencer_if #(parameter int W = 16);
  logic req_valid;
  logic req_ready;
  logic [W-1:0] req_base;
  logic [W-1:0] req_exp;
  logic [W-1:0] req_mod;
  logic rsp_valid;
  logic rsp_ready;
  logic [W-1:0] rsp_result;
  logic rsp_err;
  logic busy;
  logic mm_start;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic [W-1:0] mm_n;
  logic mm_done;
  logic [W-1:0] mm_result;
  modport slave (
    input req_valid, req_base, req_exp, req_mod, rsp_ready, mm_done, mm_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, busy, mm_start, mm_a, mm_b, mm_n
  );
  modport master (
    output req_valid, req_base, req_exp, req_mod, rsp_ready, mm_done, mm_result,
    input req_ready, rsp_valid, rsp_result, rsp_err, busy, mm_start, mm_a, mm_b, mm_n
  );
endinterface

// File: rtl/modexp_msb_find.sv
// modexp_msb_find: priority encoder returning the index of the highest set bit of exp_i
module modexp_msb_find #(
  parameter int W = 16,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  exp_i,
  output logic [IW-1:0] msb_o
);
  // lowest-to-highest scan so the last set bit seen wins
  always_comb begin
    msb_o = '0;
    for (int i = 0; i < W; i++) if (exp_i[i]) msb_o = IW'(i);
  end
endmodule

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: square-and-multiply base^exp mod n over a shared multiplier; MODEXP_SKIP_LEADING_ZEROS_EN starts at the exponent MSB
module modexp_sequencer
  import modexp_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic reset,
  modexp_sequencer_if.slave bus
);
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [W-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
  logic [W-1:0] b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [IW-1:0] idx_q, idx_d, start_bit;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, active;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  modexp_msb_find #(.W(W)) u_msb (.exp_i(bus.req_exp), .msb_o(start_bit));
`else
  assign start_bit = IW'(W - 1);
`endif
  assign active = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.req_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.rsp_valid = state_q == DONE;
  assign bus.rsp_result = res_q;
  assign bus.rsp_err = err_q;
  assign bus.mm_start = state_q == ISSUE;
  assign bus.mm_a = active ? (op_q == REDUCE ? base_q : acc_q) : '0;
  assign bus.mm_b = active ? (op_q == REDUCE ? W'(1) : op_q == SQR ? acc_q : b_q) : '0;
  assign bus.mm_n = active ? mod_q : '0;
  // next-state: accept/short-circuit requests, issue products, fold results back and walk the exponent bits
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    base_d = base_q;
    exp_d = exp_q;
    mod_d = mod_q;
    b_d = b_q;
    acc_d = acc_q;
    res_d = res_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        base_d = bus.req_base;
        exp_d = bus.req_exp;
        mod_d = bus.req_mod;
        acc_d = W'(1);
        res_d = '0;
        err_d = 1'b0;
        idx_d = start_bit;
        op_d = REDUCE;
        cnt_d = '0;
        if (bus.req_mod == '0) begin
          state_d = DONE;
          err_d = 1'b1;
        end else if (bus.req_mod == W'(1)) state_d = DONE;
        else if (bus.req_exp == '0) begin
          state_d = DONE;
          res_d = W'(1);
        end else state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (bus.mm_done) begin
        state_d = ISSUE;
        if (op_q == REDUCE) begin
          b_d = bus.mm_result;
          op_d = SQR;
        end else begin
          acc_d = bus.mm_result;
          if (op_q == SQR && exp_q[idx_q]) op_d = MUL;
          else if (idx_q == '0) begin
            state_d = DONE;
            res_d = bus.mm_result;
          end else begin
            idx_d = idx_q - IW'(1);
            op_d = SQR;
          end
        end
      end else if (cnt_q == CW'(TIMEOUT)) begin
        state_d = DONE;
        err_d = 1'b1;
        res_d = '0;
      end else cnt_d = cnt_q + CW'(1);
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= REDUCE;
      base_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      base_q <= base_d;
      exp_q <= exp_d;
      mod_q <= mod_d;
      b_q <= b_d;
      acc_q <= acc_d;
      res_q <= res_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: directed checks of modexp_sequencer against a latency-3 mock multiplier
module tb_modexp_sequencer;
  localparam int L = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mock_en = 1'b1;
  logic mm_done_m = 1'b0;
  logic [15:0] mm_res_m = '0;
  logic inj = 1'b0;
  int cd = 0;
  int starts = 0;
  int total = 0;
  int passed = 0;
  int lat;
  int s0;
  modexp_sequencer_if #(.W(16)) bus ();
  modexp_sequencer #(.W(16), .TIMEOUT(1023)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mm_done = mm_done_m | inj;
  assign bus.mm_result = inj ? 16'd8 : mm_res_m;
  // mock multiplier: result pulses L cycles after the start pulse
  always @(posedge clk) begin
    mm_done_m <= 1'b0;
    if (reset || !mock_en) cd <= 0;
    else begin
      if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) mm_done_m <= 1'b1;
      end
      if (bus.mm_start) begin
        cd <= L - 1;
        mm_res_m <= 16'((32'(bus.mm_a) * 32'(bus.mm_b)) % 32'(bus.mm_n));
      end
    end
  end
  always @(posedge clk) if (bus.mm_start) starts <= starts + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask
  function automatic int exp_lat(input logic [15:0] e);
    int pc = 0;
    int msb = 0;
    for (int i = 0; i < 16; i++) if (e[i]) begin
      pc++;
      msb = i;
    end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    return (1 + msb + 1 + pc) * (1 + L) + 1;
`else
    return (1 + 16 + pc) * (1 + L) + 1;
`endif
  endfunction
  task automatic send(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n);
    bus.req_valid = 1'b1;
    bus.req_base = b;
    bus.req_exp = e;
    bus.req_mod = n;
    check("req_ready_before_send", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_rsp(output int l);
    l = 1;
    while (!bus.rsp_valid && l < 3000) begin
      @(posedge clk);
      #1 l++;
    end
    if (!bus.rsp_valid) check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
  endtask
  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check("ack_idle", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_base = '0;
    bus.req_exp = '0;
    bus.req_mod = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.busy, bus.mm_start, bus.rsp_result}, 32'd0);
    check("reset_mm_ops", {bus.mm_a, bus.mm_b}, 32'd0);
    check("reset_mm_n", 32'(bus.mm_n), 32'd0);
    s0 = starts;
    send(16'd5, 16'd3, 16'd13);
    wait_rsp(lat);
    check("p5_3_13_result", 32'(bus.rsp_result), 32'd8);
    check("p5_3_13_err", 32'(bus.rsp_err), 32'd0);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    check("p5_3_13_latency", 32'(lat), 32'd21);
    check("p5_3_13_ops", 32'(starts - s0), 32'd5);
`else
    check("p5_3_13_latency", 32'(lat), 32'd77);
    check("p5_3_13_ops", 32'(starts - s0), 32'd19);
`endif
    ack();
    send(16'd20, 16'd2, 16'd7);
    check("reduce_operands", {bus.mm_start, 7'd0, bus.mm_a[7:0], bus.mm_b[7:0], bus.mm_n[7:0]}, {1'b1, 7'd0, 8'd20, 8'd1, 8'd7});
    wait_rsp(lat);
    check("p20_2_7_result", {bus.rsp_err, bus.rsp_result}, 32'd1);
    check("p20_2_7_latency", 32'(lat), 32'(exp_lat(16'd2)));
    ack();
    s0 = starts;
    send(16'd9, 16'd0, 16'd7);
    check("exp0_result", {bus.rsp_valid, bus.rsp_err, bus.rsp_result}, {1'b1, 1'b0, 16'd1});
    ack();
    send(16'd9, 16'd5, 16'd1);
    check("n1_result", {bus.rsp_valid, bus.rsp_err, bus.rsp_result}, {1'b1, 1'b0, 16'd0});
    ack();
    send(16'd9, 16'd5, 16'd0);
    check("n0_result", {bus.rsp_valid, bus.rsp_err, bus.rsp_result}, {1'b1, 1'b1, 16'd0});
    ack();
    check("special_no_start", 32'(starts - s0), 32'd0);
    mock_en = 1'b0;
    send(16'd5, 16'd3, 16'd13);
    wait_rsp(lat);
    check("timeout_rsp", {bus.rsp_err, bus.rsp_result}, {15'd0, 1'b1, 16'd0});
    check("timeout_latency", 32'(lat), 32'd1026);
    ack();
    mock_en = 1'b1;
    send(16'd5, 16'd3, 16'd13);
    wait_rsp(lat);
    check("after_timeout_result", {bus.rsp_err, bus.rsp_result}, 32'd8);
    ack();
    mock_en = 1'b0;
    send(16'd5, 16'd3, 16'd13);
    @(posedge clk);
    #1 check("in_wait_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midreset_idle", {bus.req_ready, bus.rsp_valid, bus.busy}, 32'b100);
    @(posedge clk);
    #1 inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    check("stale_done_ignored", {bus.req_ready, bus.rsp_valid, bus.busy, bus.mm_start}, 32'b1000);
    @(posedge clk);
    #1 check("stale_done_after", {bus.req_ready, bus.rsp_valid, bus.busy, bus.mm_start}, 32'b1000);
    mock_en = 1'b1;
    send(16'd5, 16'd3, 16'd13);
    wait_rsp(lat);
    bus.req_valid = 1'b1;
    bus.req_base = 16'd20;
    bus.req_exp = 16'd2;
    bus.req_mod = 16'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check("backpressure_hold", {bus.rsp_valid, bus.rsp_err, bus.req_ready, bus.rsp_result}, {1'b1, 1'b0, 1'b0, 16'd8});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check("handshake_to_idle", {bus.rsp_valid, bus.req_ready}, 32'b01);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("queued_accepted", {bus.busy, bus.req_ready}, 32'b10);
    wait_rsp(lat);
    check("queued_result", {bus.rsp_err, bus.rsp_result}, 32'd1);
    check("queued_latency", 32'(lat), 32'(exp_lat(16'd2)));
    ack();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/modexp_sequencer.md
# modexp_sequencer

Square-and-multiply controller that computes `base^exp mod n` by sequencing the shared `modularmult` datapath one modular product at a time. It sits beside the EX stage. The pipeline, or any other requester, hands it a request through a valid/ready handshake and gets one result back through a valid/ready response. It owns the multiplier's start/done handshake, so no requester drives the multiplier directly.

## Interface
Parameters:
- `W`, 16: operand width (base, exponent, modulus, result).
- `TIMEOUT`, 1023: maximum cycles to wait for `mm_done` before aborting with an error.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: high only in IDLE (combinational from state).
- `req_base`, in, W: base M.
- `req_exp`, in, W: exponent d.
- `req_mod`, in, W: modulus n.
- `rsp_valid`, out, 1: result available; held until accepted.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_result`, out, W: `base^exp mod n`.
- `rsp_err`, out, 1: valid with `rsp_valid`; set for n==0 or timeout, with `rsp_result`=0.
- `busy`, out, 1: high in any state other than IDLE.
- `mm_start`, out, 1: one-cycle pulse that launches a product.
- `mm_a`, out, W: multiplicand; held stable from start until done.
- `mm_b`, out, W: multiplier operand; held stable from start until done.
- `mm_n`, out, W: modulus; held stable from start until done.
- `mm_done`, in, 1: one-cycle pulse carrying `mm_result`.
- `mm_result`, in, W: `(mm_a*mm_b) mod mm_n`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. An op register selects REDUCE, SQR or MUL.
- IDLE: when `req_valid` is high, latch base, exp and mod, and clear the accumulator to 1. The next state depends on the request:
  - n==0: go to DONE with err=1 and result 0.
  - n==1: go to DONE with result 0.
  - exp==0: go to DONE with result 1.
  - Otherwise: go to ISSUE with op=REDUCE and the bit index set to the start bit.
- REDUCE computes `base*1 mod n` and stores the result as the reduced base `b`, so that `b < n` for every later product.
- Main loop, left-to-right over bit index i, from the start bit down to 0:
  - SQR: `acc = acc*acc mod n`.
  - MUL: only if `exp[i]`=1, `acc = acc*b mod n`.
  - After bit 0 is processed, go to DONE.
- ISSUE: assert `mm_start` for one cycle, drive the operands, go to WAIT, and clear the timeout counter.
- WAIT: on `mm_done`, capture `mm_result` into `b` (for REDUCE) or `acc` (for SQR/MUL). On the same cycle decide the next op and go to ISSUE, or to DONE after the last op.
- Timeout: if the counter reaches TIMEOUT in WAIT, go to DONE with err=1 and result 0.
- A `mm_done` pulse received outside WAIT is ignored.
- DONE: hold `rsp_valid`, `rsp_result` and `rsp_err` until `rsp_ready` is high, then return to IDLE. `req_ready` stays low throughout DONE, so a new request cannot overlap a pending response.
- All arithmetic is W-bit. Operands are always below n, so the accumulator never exceeds n-1.

## Timing
- Reset values:
  - State IDLE, so `req_ready`=1 on the first cycle after reset.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_err`=0, `busy`=0.
  - `mm_start`=0, `mm_a`=`mm_b`=`mm_n`=0.
  - Accumulator, counters and bit index all 0.
- Reset mid-operation aborts immediately, with no response. A `mm_done` from the aborted product is ignored.
- Let cycle 0 be the request acceptance cycle and L be the multiplier latency (`mm_done` arrives L≥1 cycles after `mm_start`).
  - Op j is issued at cycle 1+j(1+L).
  - With `ops` products in total, `rsp_valid` first rises at cycle `ops*(1+L)+1`.
  - Special cases (n≤1, exp==0) assert `rsp_valid` at cycle 1.
- `ops` = 1 + (number of bits scanned) + popcount(exp).
- If `rsp_ready` is already high when `rsp_valid` rises, the response lasts exactly one cycle and `req_ready` returns on the next cycle.

## Configuration
- `MODEXP_SKIP_LEADING_ZEROS_EN` defined: the start bit is the index of the most significant set bit of exp, so bits scanned = msb+1.
- Not defined: the start bit is always W-1, so all W bits are scanned.
- Results are identical either way; only latency differs.

## Structure
- `modexp_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE),
  - the op enum (REDUCE/SQR/MUL),
  - default W and TIMEOUT constants.
- Sub-module `modexp_msb_find` is a combinational priority encoder giving the MSB index of exp. It is instantiated only under the macro.

## Test plan
- base=5, exp=3, n=13, mock multiplier with L=3:
  - `rsp_result`=8, `rsp_err`=0.
  - With the macro: ops=5, `rsp_valid` at cycle 21.
  - Without the macro: ops=19, `rsp_valid` at cycle 77.
- base=20, exp=2, n=7 → REDUCE yields 6, final `rsp_result`=1.
- Special cases, each giving `rsp_valid` at cycle 1 with no `mm_start` pulse:
  - exp=0, n=7 → result 1.
  - n=1 → result 0.
  - n=0 → `rsp_err`=1, result 0.
- Mock multiplier never asserts `mm_done` → `rsp_err`=1 after TIMEOUT cycles in WAIT; after `rsp_ready`, the next request (5,3,13) completes correctly with result 8.
- Reset asserted mid-WAIT, with a stale `mm_done` arriving 2 cycles later → IDLE, `req_ready`=1, no `rsp_valid`, stale pulse ignored.
- Back-pressure: `rsp_ready` held low for 10 cycles → `rsp_valid`, `rsp_result` and `rsp_err` stay stable, `req_ready` stays 0, and a queued request is accepted the cycle after the response handshake.
